// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and digit limits used by the counter, lap register and display.
// Pure declarations; no latency or backpressure of its own.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam int TENTH_W = 4;
  localparam int SEC_W   = 6;

  localparam logic [TENTH_W-1:0] TENTH_MAX = 4'd9;
  localparam logic [SEC_W-1:0]   SEC_MAX   = 6'd59;

endpackage

// File: rtl/stopwatch_counter_tick_gen.sv
// Prescaler: tick is asserted combinationally in the last count of each DIV-cycle period while en is high.
// Count holds when en is low, so a pause keeps the partial period; clr/rst zero it; no backpressure.
module tick_gen #(
  parameter int DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  generate
    if (DIV < 2) begin : g_div_check
      $error("tick_gen: DIV must be at least 2");
    end
  endgenerate

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Run/pause/clear FSM and tenths/seconds counter (00.0-59.9) fed by a 0.1 s prescaler, plus lap enable.
// All outputs registered, one edge after the causing input; no backpressure, pulses are never held.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_stop_p,
  input  logic               clear_p,
  input  logic               lap_p,
  output logic [TENTH_W-1:0] tenth_sec_out,
  output logic [SEC_W-1:0]   sec_out,
  output logic               running,
  output logic               lap_en,
  output logic               wrap_p
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

  generate
    if ((DIV < 2) || ((CLK_FREQ_HZ % TICK_HZ) != 0)) begin : g_div_check
      $error("stopwatch_counter: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
    end
  endgenerate

  sw_state_t state;
  sw_state_t state_nxt;
  logic      tick;
  logic      tick_en;
  logic      at_max;

  assign tick_en = (state == RUN);
  assign at_max  = (tenth_sec_out == TENTH_MAX) && (sec_out == SEC_MAX);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .clr  (clear_p),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // clear_p outranks start_stop_p; a simultaneous start/stop is dropped
  always_comb begin
    state_nxt = state;
    if (clear_p) begin
      state_nxt = IDLE;
    end else if (start_stop_p) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_p) begin
      tenth_sec_out <= '0;
      sec_out       <= '0;
    end else if (tick) begin
      if (tenth_sec_out == TENTH_MAX) begin
        tenth_sec_out <= '0;
        sec_out       <= (sec_out == SEC_MAX) ? '0 : sec_out + SEC_W'(1);
      end else begin
        tenth_sec_out <= tenth_sec_out + TENTH_W'(1);
      end
    end
  end

  // running tracks the state register exactly, so it is loaded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      lap_en  <= 1'b0;
      wrap_p  <= 1'b0;
    end else begin
      running <= (state_nxt == RUN);
      lap_en  <= lap_p && (state == RUN) && !clear_p;
      wrap_p  <= tick && at_max && !clear_p;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Randomized and directed bench for stopwatch_counter against a tenths-elapsed reference model.
module tb_stopwatch_counter;

  localparam int CLK_HZ = 40;
  localparam int TICK   = 10;
  localparam int DIV    = CLK_HZ / TICK;

  logic       clk          = 1'b0;
  logic       rst          = 1'b1;
  logic       start_stop_p = 1'b0;
  logic       clear_p      = 1'b0;
  logic       lap_p        = 1'b0;
  logic [3:0] tenth_sec_out;
  logic [5:0] sec_out;
  logic       running;
  logic       lap_en;
  logic       wrap_p;

  stopwatch_counter #(
    .CLK_FREQ_HZ (CLK_HZ),
    .TICK_HZ     (TICK)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_stop_p  (start_stop_p),
    .clear_p       (clear_p),
    .lap_p         (lap_p),
    .tenth_sec_out (tenth_sec_out),
    .sec_out       (sec_out),
    .running       (running),
    .lap_en        (lap_en),
    .wrap_p        (wrap_p)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: mode 0=idle 1=run 2=pause, phase within a tick period, elapsed tenths mod 600
  int m_mode  = 0;
  int m_phase = 0;
  int m_t     = 0;
  int m_lap   = 0;
  int m_wrap  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit c, input bit l);
    m_lap  = 0;
    m_wrap = 0;
    if (r || c) begin
      m_mode  = 0;
      m_phase = 0;
      m_t     = 0;
    end else begin
      if (m_mode == 1) begin
        m_phase = m_phase + 1;
        if (m_phase == DIV) begin
          m_phase = 0;
          m_t     = (m_t + 1) % 600;
          m_wrap  = (m_t == 0) ? 1 : 0;
        end
        m_lap = l ? 1 : 0;
      end
      if (s) m_mode = (m_mode == 1) ? 2 : 1;
    end
  endtask

  function automatic int disp();
    return int'(sec_out) * 10 + int'(tenth_sec_out);
  endfunction

  task automatic cycle(input bit r, input bit s, input bit c, input bit l);
    rst          = r;
    start_stop_p = s;
    clear_p      = c;
    lap_p        = l;
    @(posedge clk);
    model_edge(r, s, c, l);
    #1;
    chk("tenth",   int'(tenth_sec_out), m_t % 10);
    chk("sec",     int'(sec_out),       m_t / 10);
    chk("running", int'(running),       (m_mode == 1) ? 1 : 0);
    chk("lap_en",  int'(lap_en),        m_lap);
    chk("wrap_p",  int'(wrap_p),        m_wrap);
    rst          = 1'b0;
    start_stop_p = 1'b0;
    clear_p      = 1'b0;
    lap_p        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_t != target && guard < 3000) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("reach_target", disp(), target);
  endtask

  task automatic run_to_phase(input int ph);
    int guard;
    guard = 0;
    while (m_phase != ph && guard < 2 * DIV) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("reach_phase_timeout", (guard < 2 * DIV) ? 1 : 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    int wraps;
    int not_run;

    // Reset with random pulses
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("reset_running", int'(running), 0);
    chk("reset_count", disp(), 0);

    // Start and first-tick / first-second latency
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("run_after_start", int'(running), 1);
    idle(3);
    chk("tenth_before_edge4", int'(tenth_sec_out), 0);
    idle(1);
    chk("tenth_at_edge4", int'(tenth_sec_out), 1);
    idle(35);
    chk("count_at_edge39", disp(), 9);
    idle(1);
    chk("sec_at_edge40", int'(sec_out), 1);
    chk("tenth_at_edge40", int'(tenth_sec_out), 0);

    // Pause with the held prescaler at 2, resume, tick two cycles later
    run_to_phase(1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    saved = disp();
    idle(20);
    chk("pause_hold", disp(), saved);
    chk("pause_running", int'(running), 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("resume_plus1", disp(), saved);
    idle(1);
    chk("resume_plus2", disp(), (saved + 1) % 600);

    // Wrap: 600 ticks pass 59.9 -> 00.0 exactly once
    wraps   = 0;
    not_run = 0;
    for (int i = 0; i < 600 * DIV; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (wrap_p) wraps++;
      if (!running) not_run++;
    end
    chk("wrap_count", wraps, 1);
    chk("running_through_wrap", not_run, 0);

    // Lap at 35.2, lap on a tick edge, lap in pause
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_to(352);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lap_en_352", int'(lap_en), 1);
    chk("lap_value_352", disp(), 352);
    idle(1);
    chk("lap_en_one_cycle", int'(lap_en), 0);
    run_to_phase(DIV - 1);
    saved = disp();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lap_en_on_tick", int'(lap_en), 1);
    chk("lap_value_on_tick", disp(), saved + 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lap_in_pause", int'(lap_en), 0);
    idle(1);
    chk("lap_in_pause_next", int'(lap_en), 0);

    // Clear beats start/stop and lap at 15.8
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_to(158);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clear_running", int'(running), 0);
    chk("clear_lap_en", int'(lap_en), 0);
    chk("clear_count", disp(), 0);
    idle(2);
    chk("clear_stays_idle", int'(running), 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(DIV - 1);
    chk("restart_before_div", disp(), 0);
    idle(1);
    chk("restart_at_div", disp(), 1);

    // Random pulse traffic, including occasional reset and clear
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
